mdu_hilo_unit: RTL and testbench

- Multi-cycle multiply/divide responder behind the EX-stage start/busy handshake.
- Owns the HI/LO architectural registers and implements MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Supports interrupt suppression of a same-cycle start, and a one-cycle rollback that restores HI/LO when the issuing instruction is flushed by an exception.
- The EX stage stalls MFHI/MFLO and any new mult/div while busy is high.

---
 rtl/mdu_hilo_if.sv | 23 ++
 rtl/mdu_hilo_unit.sv | 145 ++++++++++++++
 tb/tb_mdu_hilo_unit.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_hilo_if.sv
// EX-stage <-> multiply/divide unit handshake: operation request, undo/interrupt
// controls, and the HI/LO/busy view returned to the pipeline.
interface mdu_hilo_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        int_req;
  logic        rollback;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, int_req, rollback,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, a, b, int_req, rollback,
    output busy, hi, lo
  );
endinterface

// File: rtl/mdu_hilo_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU responder owning HI/LO, with MTHI/MTLO,
// interrupt suppression of start and a single-level HI/LO rollback.
module mdu_hilo_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic        clk,
  input logic        reset,
  mdu_hilo_if.slave  mdu
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [1:0]         op_q;   // [1]=divide, [0]=unsigned
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;
  logic [31:0]        bak_hi;
  logic [31:0]        bak_lo;
  logic               busy_q;

  logic               acc;
  logic               neg_a;
  logic               neg_b;
  logic [63:0]        mul_a;
  logic [63:0]        mul_b;
  logic [63:0]        prod;
  logic [31:0]        mag_a;
  logic [31:0]        mag_b;
  logic               div_zero;
  logic [31:0]        uq;
  logic [31:0]        ur;
  logic [31:0]        quo;
  logic [31:0]        rem;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;

  assign mdu.busy = busy_q;
  assign mdu.hi   = hi_q;
  assign mdu.lo   = lo_q;

  assign acc = mdu.start & ~mdu.int_req & ~busy_q & (mdu.op <= OP_MTLO);

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000
  // with a zero remainder instead of needing a special case.
  always_comb begin
    neg_a    = ~op_q[0] & a_q[31];
    neg_b    = ~op_q[0] & b_q[31];
    mul_a    = {{32{neg_a}}, a_q};
    mul_b    = {{32{neg_b}}, b_q};
    prod     = mul_a * mul_b;
    mag_a    = neg_a ? (~a_q + 32'd1) : a_q;
    mag_b    = neg_b ? (~b_q + 32'd1) : b_q;
    div_zero = (b_q == '0);
    uq       = div_zero ? '0 : (mag_a / mag_b);
    ur       = div_zero ? '0 : (mag_a % mag_b);
    quo      = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
    rem      = neg_a ? (~ur + 32'd1) : ur;
    res_hi   = op_q[1] ? rem : prod[63:32];
    res_lo   = op_q[1] ? quo : prod[31:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      bak_hi <= '0;
      bak_lo <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mdu.rollback) begin
            hi_q <= bak_hi;
            lo_q <= bak_lo;
          end else if (acc) begin
            case (mdu.op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                a_q    <= mdu.a;
                b_q    <= mdu.b;
                op_q   <= mdu.op[1:0];
                bak_hi <= hi_q;
                bak_lo <= lo_q;
                cnt    <= mdu.op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                busy_q <= 1'b1;
                state  <= RUN;
              end
              OP_MTHI: begin
                bak_hi <= hi_q;
                bak_lo <= lo_q;
                hi_q   <= mdu.a;
              end
              OP_MTLO: begin
                bak_hi <= hi_q;
                bak_lo <= lo_q;
                lo_q   <= mdu.a;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          // HI/LO are untouched until completion, so aborting needs no restore.
          if (mdu.rollback) begin
            cnt    <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (cnt <= CNT_W'(1)) begin
            if (!(op_q[1] && div_zero)) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
            cnt    <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// Self-checking bench for mdu_hilo_unit: directed vector table, hand-written
// rollback/interrupt/reset sequences and randomized ops against a reference model.
module tb_mdu_hilo_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  mdu_hilo_if bus ();

  mdu_hilo_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_hi, m_lo, m_bhi, m_blo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int exp_cycles(input logic [2:0] o);
    case (o)
      3'd0, 3'd1: return MC;
      3'd2, 3'd3: return DC;
      default:    return 0;
    endcase
  endfunction

  // Architectural effect of one accepted op, straight from the arithmetic rules.
  task automatic model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, q, r;
    longint unsigned up;
    if (o <= 3'd5) begin
      m_bhi = m_hi;
      m_blo = m_lo;
    end
    case (o)
      3'd0: begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q  = sx * sy;
        m_hi = 32'(q >>> 32);
        m_lo = 32'(q);
      end
      3'd1: begin
        up = {32'd0, x} * {32'd0, y};
        m_hi = 32'(up >> 32);
        m_lo = 32'(up);
      end
      3'd2: if (y != 0) begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q  = sx / sy;
        r  = sx % sy;
        m_lo = 32'(q);
        m_hi = 32'(r);
      end
      3'd3: if (y != 0) begin
        m_lo = x / y;
        m_hi = x % y;
      end
      3'd4: m_hi = x;
      3'd5: m_lo = x;
      default: ;
    endcase
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = '0; m_lo = '0; m_bhi = '0; m_blo = '0;
  endtask

  // One-cycle start pulse; returns how many cycles busy stayed high.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int cyc);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    tick();
    bus.start = 1'b0; bus.op = 3'($urandom); bus.a = $urandom; bus.b = $urandom;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      cyc++;
      tick();
    end
    model_op(o, x, y);
  endtask

  task automatic rollback_pulse;
    bus.rollback = 1'b1;
    tick();
    bus.rollback = 1'b0;
    m_hi = m_bhi;
    m_lo = m_blo;
  endtask

  initial begin
    int          cyc;
    logic [31:0] pre_hi, pre_lo, x, y;
    logic [2:0]  o;

    tbl[0] = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MC};
    tbl[1] = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, MC};
    tbl[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    tbl[3] = '{3'd3, 32'd7,        32'd2,        32'd1,        32'd3,        DC};
    tbl[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, DC};
    tbl[5] = '{3'd4, 32'h00000011, 32'd0,        32'h00000011, 32'h80000000, 0};
    tbl[6] = '{3'd5, 32'h00000022, 32'd0,        32'h00000011, 32'h00000022, 0};
    tbl[7] = '{3'd2, 32'h12345678, 32'd0,        32'h00000011, 32'h00000022, DC};
    tbl[8] = '{3'd3, 32'hDEADBEEF, 32'd0,        32'h00000011, 32'h00000022, DC};

    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    bus.int_req = 1'b0; bus.rollback = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    do_reset();
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_hi", {32'd0, bus.hi}, 64'd0);
    check("reset_lo", {32'd0, bus.lo}, 64'd0);

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, cyc);
      check($sformatf("tbl%0d_cycles", i), 64'(cyc), 64'(tbl[i].cyc));
      check($sformatf("tbl%0d_hi", i), {32'd0, bus.hi}, {32'd0, tbl[i].hi});
      check($sformatf("tbl%0d_lo", i), {32'd0, bus.lo}, {32'd0, tbl[i].lo});
    end

    // MTHI then rollback after reset; a second rollback changes nothing.
    do_reset();
    run_op(3'd5, 32'h5, 32'd0, cyc);
    run_op(3'd4, 32'h12345678, 32'd0, cyc);
    check("mthi_busy", {63'd0, bus.busy}, 64'd0);
    check("mthi_hi", {32'd0, bus.hi}, 64'h12345678);
    rollback_pulse();
    check("rb_idle_hi", {32'd0, bus.hi}, 64'd0);
    check("rb_idle_lo", {32'd0, bus.lo}, 64'd5);
    rollback_pulse();
    check("rb_twice_hi", {32'd0, bus.hi}, 64'd0);
    check("rb_twice_lo", {32'd0, bus.lo}, 64'd5);

    // Start suppressed by int_req.
    run_op(3'd4, 32'hAAAA0001, 32'd0, cyc);
    run_op(3'd5, 32'hBBBB0002, 32'd0, cyc);
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd7; bus.b = 32'd9; bus.int_req = 1'b1;
    tick();
    bus.start = 1'b0; bus.int_req = 1'b0;
    check("intreq_busy", {63'd0, bus.busy}, 64'd0);
    tick();
    check("intreq_busy2", {63'd0, bus.busy}, 64'd0);
    check("intreq_hi", {32'd0, bus.hi}, 64'hAAAA0001);
    check("intreq_lo", {32'd0, bus.lo}, 64'hBBBB0002);

    // Rollback during the 3rd RUN cycle aborts the MULT.
    pre_hi = m_hi; pre_lo = m_lo;
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd7; bus.b = 32'd9;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("rbrun_busy_before", {63'd0, bus.busy}, 64'd1);
    bus.rollback = 1'b1;
    tick();
    bus.rollback = 1'b0;
    check("rbrun_busy", {63'd0, bus.busy}, 64'd0);
    check("rbrun_hi", {32'd0, bus.hi}, {32'd0, pre_hi});
    check("rbrun_lo", {32'd0, bus.lo}, {32'd0, pre_lo});
    repeat (8) tick();
    check("rbrun_late_lo", {32'd0, bus.lo}, {32'd0, pre_lo});

    // Rollback one cycle after completion restores pre-MULT values.
    run_op(3'd0, 32'd7, 32'd9, cyc);
    check("rbdone_cycles", 64'(cyc), 64'(MC));
    check("rbdone_res_lo", {32'd0, bus.lo}, 64'd63);
    rollback_pulse();
    check("rbdone_hi", {32'd0, bus.hi}, {32'd0, pre_hi});
    check("rbdone_lo", {32'd0, bus.lo}, {32'd0, pre_lo});

    // Rollback and start together: rollback wins.
    run_op(3'd4, 32'hCAFE0001, 32'd0, cyc);
    bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd3; bus.b = 32'd4; bus.rollback = 1'b1;
    tick();
    bus.start = 1'b0; bus.rollback = 1'b0;
    m_hi = m_bhi; m_lo = m_blo;
    check("rbstart_busy", {63'd0, bus.busy}, 64'd0);
    check("rbstart_hi", {32'd0, bus.hi}, {32'd0, pre_hi});
    check("rbstart_lo", {32'd0, bus.lo}, {32'd0, m_lo});

    // Start while busy is ignored; original MULT lands on schedule.
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'hFFFFFFFE; bus.b = 32'd3;
    tick();
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      cyc++;
      if (cyc == 2) begin
        bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd100; bus.b = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    model_op(3'd0, 32'hFFFFFFFE, 32'd3);
    check("busystart_cycles", 64'(cyc), 64'(MC));
    check("busystart_hi", {32'd0, bus.hi}, 64'hFFFFFFFF);
    check("busystart_lo", {32'd0, bus.lo}, 64'hFFFFFFFA);
    tick();
    check("busystart_after", {63'd0, bus.busy}, 64'd0);

    // Reset in the 4th RUN cycle of a DIV.
    run_op(3'd4, 32'h55, 32'd0, cyc);
    bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd100; bus.b = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    check("rstrun_busy_before", {63'd0, bus.busy}, 64'd1);
    do_reset();
    check("rstrun_busy", {63'd0, bus.busy}, 64'd0);
    check("rstrun_hi", {32'd0, bus.hi}, 64'd0);
    check("rstrun_lo", {32'd0, bus.lo}, 64'd0);
    repeat (DC + 2) tick();
    check("rstrun_late_busy", {63'd0, bus.busy}, 64'd0);
    check("rstrun_late_lo", {32'd0, bus.lo}, 64'd0);

    // Randomized ops and idle rollbacks against the model.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        rollback_pulse();
        check($sformatf("rnd%0d_rb_hi", i), {32'd0, bus.hi}, {32'd0, m_hi});
        check($sformatf("rnd%0d_rb_lo", i), {32'd0, bus.lo}, {32'd0, m_lo});
      end else begin
        o = 3'($urandom_range(0, 7));
        x = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
        case ($urandom_range(0, 7))
          0:       y = 32'd0;
          1:       y = 32'hFFFFFFFF;
          2:       y = 32'($urandom_range(1, 20));
          default: y = $urandom;
        endcase
        run_op(o, x, y, cyc);
        check($sformatf("rnd%0d_op%0d_cycles", i, o), 64'(cyc), 64'(exp_cycles(o)));
        check($sformatf("rnd%0d_op%0d_hi", i, o), {32'd0, bus.hi}, {32'd0, m_hi});
        check($sformatf("rnd%0d_op%0d_lo", i, o), {32'd0, bus.lo}, {32'd0, m_lo});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
